alu_issue_stage: RTL and testbench

Operand-issue pipeline stage directly upstream of the ALU. Accepts one decoded instruction per handshake, selects register or extended-immediate operands, applies writeback forwarding, and holds `opCode`/`dataA`/`dataB` in an output register that drives the ALU inputs. It has valid/ready flow control on both sides, a flush input, and illegal-opcode screening.

---
 rtl/alu_issue_stage.sv | 153 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU operand-issue stage: operand select, writeback forwarding,
// illegal-opcode screening and a one-entry output register.
module alu_issue_stage #(
  parameter int IMM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [4:0]       inOpCode,
  input  logic [4:0]       rsAddr,
  input  logic [4:0]       rtAddr,
  input  logic [31:0]      rsData,
  input  logic [31:0]      rtData,
  input  logic [IMM_W-1:0] imm,
  input  logic [4:0]       rdAddr,
  input  logic             wbValid,
  input  logic [4:0]       wbAddr,
  input  logic [31:0]      wbData,
  input  logic             flush,
  output logic             outValid,
  input  logic             outReady,
  output logic [4:0]       opCode,
  output logic [31:0]      dataA,
  output logic [31:0]      dataB,
  output logic [4:0]       outRdAddr,
  output logic             illegalOp,
  output logic [CNT_W-1:0] issuedCount
);

  localparam logic [4:0] OP_NOT  = 5'b01111;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  logic             valid_q, valid_d;
  logic [4:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        is_illegal;
  logic        is_imm;
  logic        is_zext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] b_sel;

  assign inReady = !valid_q || outReady;
  assign accept  = inValid && inReady;

  // Decode opcode class, forward operands and pick dataB
  always_comb begin
    is_illegal = inOpCode > 5'd19;
    is_imm     = 1'b0;
    is_zext    = 1'b0;
    case (inOpCode)
      5'b00001, 5'b00011, 5'b00101,
      5'b00111, 5'b01010, 5'b10011: is_imm = 1'b1;
      OP_ANDI, OP_ORI: begin
        is_imm  = 1'b1;
        is_zext = 1'b1;
      end
      default: is_imm = 1'b0;
    endcase

    if (rsAddr == 5'd0)
      rs_val = '0;
    else if (wbValid && wbAddr == rsAddr)
      rs_val = wbData;
    else
      rs_val = rsData;

    if (rtAddr == 5'd0)
      rt_val = '0;
    else if (wbValid && wbAddr == rtAddr)
      rt_val = wbData;
    else
      rt_val = rtData;

    if (is_zext)
      imm_ext = {{(32-IMM_W){1'b0}}, imm};
    else
      imm_ext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};

    if (inOpCode == OP_NOT)
      b_sel = '0;
    else if (is_imm)
      b_sel = imm_ext;
    else
      b_sel = rt_val;
  end

  // Next-state: flush beats load, load beats pop; count real issues
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ill_d   = accept && is_illegal;

    if (valid_q && outReady && !flush && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept && !is_illegal) begin
      valid_d = 1'b1;
      op_d    = inOpCode;
      a_d     = rs_val;
      b_d     = b_sel;
      rd_d    = rdAddr;
    end else if (outReady) begin
      valid_d = 1'b0;
    end
  end

  // Output register bank with asynchronous clear
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outValid    = valid_q;
  assign opCode      = op_q;
  assign dataA       = a_q;
  assign dataB       = b_q;
  assign outRdAddr   = rd_q;
  assign illegalOp   = ill_q;
  assign issuedCount = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed cases plus random
// traffic against a behavioural model of the issue stage.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inOpCode;
  logic [4:0]  rsAddr, rtAddr;
  logic [31:0] rsData, rtData;
  logic [15:0] imm;
  logic [4:0]  rdAddr;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [4:0]  opCode;
  logic [31:0] dataA, dataB;
  logic [4:0]  outRdAddr;
  logic        illegalOp;
  logic [15:0] issuedCount;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  bit          m_valid;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;
  bit          m_ill;
  int          m_cnt;

  alu_issue_stage dut (
    .clock(clock), .resetN(resetN),
    .inValid(inValid), .inReady(inReady),
    .inOpCode(inOpCode),
    .rsAddr(rsAddr), .rtAddr(rtAddr),
    .rsData(rsData), .rtData(rtData),
    .imm(imm), .rdAddr(rdAddr),
    .wbValid(wbValid), .wbAddr(wbAddr),
    .wbData(wbData), .flush(flush),
    .outValid(outValid), .outReady(outReady),
    .opCode(opCode), .dataA(dataA), .dataB(dataB),
    .outRdAddr(outRdAddr), .illegalOp(illegalOp),
    .issuedCount(issuedCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] a,
                                      input logic [31:0] d);
    if (a == 0) return 32'd0;
    if (wbValid && wbAddr == a) return wbData;
    return d;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_a = 0; m_b = 0;
    m_rd = 0; m_ill = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit rdy, acc, legal;
    int op;
    op    = int'(inOpCode);
    rdy   = !m_valid || outReady;
    acc   = inValid && rdy;
    legal = op <= 19;
    if (m_valid && outReady && !flush && m_cnt < 65535)
      m_cnt++;
    m_ill = acc && !legal;
    if (flush) begin
      m_valid = 0;
    end else if (acc && legal) begin
      m_valid = 1;
      m_op    = inOpCode;
      m_rd    = rdAddr;
      m_a     = src(rsAddr, rsData);
      if (op == 15)
        m_b = 0;
      else if (op == 12 || op == 14)
        m_b = 32'(imm);
      else if (op inside {1, 3, 5, 7, 10, 19})
        m_b = 32'($signed(imm));
      else
        m_b = src(rtAddr, rtData);
    end else if (acc || (m_valid && outReady)) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outs(input string pfx);
    check({pfx, ".outValid"}, 32'(outValid), 32'(m_valid));
    check({pfx, ".opCode"}, 32'(opCode), 32'(m_op));
    check({pfx, ".dataA"}, dataA, m_a);
    check({pfx, ".dataB"}, dataB, m_b);
    check({pfx, ".rd"}, 32'(outRdAddr), 32'(m_rd));
    check({pfx, ".illegal"}, 32'(illegalOp), 32'(m_ill));
    check({pfx, ".count"}, 32'(issuedCount), 32'(m_cnt));
  endtask

  // one clock: inputs already driven, ends at the negedge
  task automatic cyc(input bit en);
    #1;
    if (en)
      check("inReady", 32'(inReady),
            32'(!m_valid || outReady));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (en) check_outs("cyc");
  endtask

  task automatic idle_inputs();
    inValid = 0; inOpCode = 0; rsAddr = 0; rtAddr = 0;
    rsData = 0; rtData = 0; imm = 0; rdAddr = 0;
    wbValid = 0; wbAddr = 0; wbData = 0; flush = 0;
    outReady = 1;
  endtask

  task automatic rand_inputs();
    inValid  = $urandom_range(0, 3) != 0;
    inOpCode = 5'($urandom_range(0, 31));
    rsAddr   = 5'($urandom_range(0, 3));
    rtAddr   = 5'($urandom_range(0, 3));
    rsData   = $urandom;
    rtData   = $urandom;
    imm      = 16'($urandom);
    rdAddr   = 5'($urandom);
    wbValid  = 1'($urandom);
    wbAddr   = 5'($urandom_range(0, 3));
    wbData   = $urandom;
    flush    = $urandom_range(0, 15) == 0;
    outReady = $urandom_range(0, 3) != 0;
  endtask

  initial begin
    int c0;
    idle_inputs();
    resetN = 0;
    model_reset();
    #3;
    check_outs("reset");
    check("reset.inReady", 32'(inReady), 32'd1);
    @(negedge clock);
    resetN = 1;

    // add 5 + 7
    inValid = 1; inOpCode = 5'b00000;
    rsAddr = 1; rtAddr = 2; rsData = 5; rtData = 7; rdAddr = 9;
    cyc(1);
    check("add.valid", 32'(outValid), 32'd1);
    check("add.a", dataA, 32'd5);
    check("add.b", dataB, 32'd7);

    // addi / andi extension
    inOpCode = 5'b00001; imm = 16'hFFFF;
    cyc(1);
    check("addi.b", dataB, 32'hFFFFFFFF);
    inOpCode = 5'b01100;
    cyc(1);
    check("andi.b", dataB, 32'h0000FFFF);

    // forwarding, and address 0
    inOpCode = 5'b00000; rsAddr = 3; rsData = 1;
    wbValid = 1; wbAddr = 3; wbData = 32'hDEADBEEF;
    cyc(1);
    check("fwd.a", dataA, 32'hDEADBEEF);
    rsAddr = 0; wbAddr = 0; rsData = 123;
    cyc(1);
    check("zero.a", dataA, 32'd0);
    wbValid = 0;

    // backpressure: held for 3 cycles, then pop + accept
    rsAddr = 1; rsData = 32'h11; outReady = 1;
    cyc(1);
    outReady = 0; rsData = 32'h22;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("bp.ready", 32'(inReady), 32'd0);
      check("bp.a_held", dataA, 32'h11);
    end
    c0 = int'(issuedCount);
    outReady = 1;
    cyc(1);
    check("bp.count", 32'(issuedCount), 32'(c0 + 1));
    check("bp.a_new", dataA, 32'h22);

    // illegal opcode
    inOpCode = 5'b10110;
    cyc(1);
    check("ill.pulse", 32'(illegalOp), 32'd1);
    check("ill.valid", 32'(outValid), 32'd0);
    inValid = 0;
    cyc(1);
    check("ill.clear", 32'(illegalOp), 32'd0);

    // flush while held
    inValid = 1; inOpCode = 5'b00000;
    cyc(1);
    inValid = 0; outReady = 0;
    c0 = int'(issuedCount);
    flush = 1;
    cyc(1);
    check("flush.valid", 32'(outValid), 32'd0);
    check("flush.count", 32'(issuedCount), 32'(c0));
    flush = 0; outReady = 1;
    cyc(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cyc(1);
    end

    // saturate the issue counter
    idle_inputs();
    inValid = 1; inOpCode = 5'b00000; rsAddr = 1; rsData = 3;
    for (int i = 0; i < 65540; i++)
      cyc(0);
    check("sat.count", 32'(issuedCount), 32'hFFFF);
    cyc(1);
    check("sat.hold", 32'(issuedCount), 32'hFFFF);

    // asynchronous reset mid-stream
    #2;
    resetN = 0;
    #1;
    model_reset();
    check_outs("areset");
    check("areset.inReady", 32'(inReady), 32'd1);
    @(negedge clock);
    resetN = 1;
    idle_inputs();
    cyc(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
